// File: rtl/temp_sense_if.sv
// Signal bundle between the temperature-sensor sequencer, the sensor front end and the readout logic.
// The slave modport is the sequencer. Voutc comes from the analog comparator, not from the readout side.
interface temp_sense_if;
    logic       start;
    logic       cont;
    logic       Voutc;
    logic       sensor_en;
    logic       busy;
    logic       done;
    logic [7:0] T;
    logic       ovf;

    modport master (
        output start, cont, Voutc,
        input  sensor_en, busy, done, T, ovf
    );

    modport slave (
        input  start, cont, Voutc,
        output sensor_en, busy, done, T, ovf
    );
endinterface

// File: rtl/temp_sense_seq.sv
// Temperature-sensor measurement sequencer: settle, count comparator edges over 2^AVG_LOG2 windows,
// and publish the truncated average with a one-cycle done strobe.
//
// state     | meaning
// S_IDLE    | sensor off, waiting for start
// S_SETTLE  | sensor on, settling timer running, edges ignored
// S_MEASURE | back-to-back counting windows, edges counted
// S_DONE    | one cycle: result published, then re-measure (cont) or go idle
module temp_sense_seq #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned WINDOW_CYCLES = 800000,
    parameter int unsigned AVG_LOG2      = 2
) (
    input logic         clk,
    input logic         rst_n,
    temp_sense_if.slave ts
);
    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned ACC_W   = 8 + AVG_LOG2;
    localparam int unsigned IDX_W   = AVG_LOG2 + 1;

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_WIN  = IDX_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [TMR_W-1:0] tmr_q;
    logic [IDX_W-1:0] win_idx_q;
    logic [7:0]       win_cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             sticky_q;
    logic             done_q;
    logic [7:0]       t_q;
    logic             ovf_q;

    logic       edge_det;
    logic       tmr_tc;
    logic       last_win;
    logic       sat_hit;
    logic [7:0] cnt_next;
    logic       ld_settle;
    logic       meas_init;
    logic       active;

    // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is the previous sample for edge detection
    assign edge_det = sync_q[1] & ~sync_q[2];
    assign tmr_tc   = (tmr_q == '0);
    assign last_win = (win_idx_q == LAST_WIN);
    assign sat_hit  = edge_det && (win_cnt_q == 8'hFF);
    assign cnt_next = (edge_det && (win_cnt_q != 8'hFF)) ? win_cnt_q + 8'd1 : win_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_settle = 1'b0;
        meas_init = 1'b0;
        active    = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                active = 1'b0;
                if (ts.start) begin
                    state_d   = S_SETTLE;
                    ld_settle = 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_tc) begin
                    state_d   = S_MEASURE;
                    meas_init = 1'b1;
                end
            end
            S_MEASURE: begin
                if (tmr_tc && last_win) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ts.cont) begin
                    state_d   = S_MEASURE;
                    meas_init = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            tmr_q     <= '0;
            win_idx_q <= '0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            done_q    <= 1'b0;
            t_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], ts.Voutc};
            done_q <= (state_q == S_DONE);

            if (ld_settle) begin
                tmr_q <= SETTLE_LD;
            end else if (meas_init) begin
                tmr_q     <= WINDOW_LD;
                win_idx_q <= '0;
                win_cnt_q <= '0;
            end else if (state_q == S_SETTLE) begin
                tmr_q <= tmr_q - 1'b1;
            end else if (state_q == S_MEASURE) begin
                // window end: the final cycle's edge is folded in through cnt_next
                if (tmr_tc) begin
                    tmr_q     <= WINDOW_LD;
                    win_idx_q <= win_idx_q + 1'b1;
                    win_cnt_q <= '0;
                    acc_q     <= acc_q + ACC_W'(cnt_next);
                end else begin
                    tmr_q     <= tmr_q - 1'b1;
                    win_cnt_q <= cnt_next;
                end
                if (sat_hit) begin
                    sticky_q <= 1'b1;
                end
            end

            if (state_q == S_DONE) begin
                t_q      <= 8'(acc_q >> AVG_LOG2);
                ovf_q    <= sticky_q;
                acc_q    <= '0;
                sticky_q <= 1'b0;
            end
        end
    end

    assign ts.sensor_en = active;
    assign ts.busy      = active;
    assign ts.done      = done_q;
    assign ts.T         = t_q;
    assign ts.ovf       = ovf_q;
endmodule
